// File: rtl/flash_read_ctrl.sv
// SPI flash read controller (mode 0, sck = sys_clk/4): issues READ plus a 24-bit address,
// then shifts NUM_DATA bytes in on miso and strobes each one out on rd_data/rd_valid.
module flash_read_ctrl #(
  parameter logic [8:0] NUM_DATA  = 9'd100,
  parameter logic [7:0] READ_INST = 8'h03,
  parameter logic [7:0] S_ADDR    = 8'h00,
  parameter logic [7:0] P_ADDR    = 8'h04,
  parameter logic [7:0] B_ADDR    = 8'h25
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  input  logic       miso,
  output logic       sck,
  output logic       cs_n,
  output logic       mosi,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    CS_SETUP = 5'b00010,
    CMD      = 5'b00100,
    RECV     = 5'b01000,
    CS_HOLD  = 5'b10000
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt_clk, cnt_clk_nxt;
  logic [8:0]  cnt_byte, cnt_byte_nxt;
  logic [7:0]  shift_reg;
  logic [7:0]  cmd_byte;
  logic        slot_end;

  assign slot_end = (cnt_clk == 5'd31);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (key && !done) state_nxt = CS_SETUP;
      CS_SETUP: if (slot_end) state_nxt = CMD;
      CMD:      if (slot_end && cnt_byte == 9'd4) state_nxt = RECV;
      RECV:     if (slot_end && cnt_byte == NUM_DATA + 9'd4) state_nxt = CS_HOLD;
      CS_HOLD:  if (slot_end) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Slot counters: cnt_byte 0 = CS_SETUP, 1..4 = command bytes, 5.. = data, last = CS_HOLD
  always_comb begin
    cnt_clk_nxt  = 5'd0;
    cnt_byte_nxt = 9'd0;
    if (state != IDLE) begin
      cnt_clk_nxt = cnt_clk + 5'd1;
      if (!slot_end)
        cnt_byte_nxt = cnt_byte;
      else if (state != CS_HOLD)
        cnt_byte_nxt = cnt_byte + 9'd1;
    end
  end

  always_comb begin
    case (cnt_byte_nxt[1:0])
      2'd1:    cmd_byte = READ_INST;
      2'd2:    cmd_byte = S_ADDR;
      2'd3:    cmd_byte = P_ADDR;
      default: cmd_byte = B_ADDR;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt_clk  <= 5'd0;
      cnt_byte <= 9'd0;
    end else begin
      state    <= state_nxt;
      cnt_clk  <= cnt_clk_nxt;
      cnt_byte <= cnt_byte_nxt;
    end
  end

  // Pin outputs are registered from next-state values so they line up with state/cnt_clk
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck  <= 1'b0;
      cs_n <= 1'b1;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      sck  <= ((state_nxt == CMD) || (state_nxt == RECV)) && cnt_clk_nxt[1];
      cs_n <= (state_nxt == IDLE);
      mosi <= (state_nxt == CMD) ? cmd_byte[~cnt_clk_nxt[4:2]] : 1'b0;
      busy <= (state_nxt != IDLE);
      done <= (state == CS_HOLD) && (state_nxt == IDLE);
    end
  end

  // miso is captured mid-high of sck (end of phase 2), MSB first
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      shift_reg <= 8'd0;
      rd_data   <= 8'd0;
      rd_valid  <= 1'b0;
    end else begin
      if (state == RECV && cnt_clk[1:0] == 2'd2)
        shift_reg <= {shift_reg[6:0], miso};
      rd_valid <= (state == RECV) && slot_end;
      if (state == RECV && slot_end)
        rd_data <= shift_reg;
    end
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: behavioural SPI flash model, read-data scoreboard,
// chip-select/sck timing monitor, and a second instance with NUM_DATA=1.
module tb_flash_read_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key = 1'b0;
  logic       miso = 1'b0;
  logic       sck, cs_n, mosi, rd_valid, busy, done;
  logic [7:0] rd_data;

  logic       key1 = 1'b0;
  logic       miso1 = 1'b1;
  logic       sck1, cs_n1, mosi1, rd_valid1, busy1, done1;
  logic [7:0] rd_data1;

  int n_cmp = 0;
  int n_err = 0;

  always #10 sys_clk = ~sys_clk;

  flash_read_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .miso(miso),
    .sck(sck), .cs_n(cs_n), .mosi(mosi), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  flash_read_ctrl #(.NUM_DATA(9'd1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key1), .miso(miso1),
    .sck(sck1), .cs_n(cs_n1), .mosi(mosi1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash model: captures 32 command bits on sck rise, shifts data out on sck fall
  logic [7:0]  mem [256];
  logic [31:0] cmd_sh = 32'd0;
  logic [31:0] cmd_last = 32'd0;
  int          bit_cnt = 0;

  always @(posedge sck or negedge sck or posedge cs_n) begin
    if (cs_n) begin
      bit_cnt = 0;
      cmd_sh  = 32'd0;
    end else if (sck) begin
      if (bit_cnt < 32) cmd_sh = {cmd_sh[30:0], mosi};
      bit_cnt++;
      if (bit_cnt == 32) cmd_last = cmd_sh;
    end else if (bit_cnt >= 32) begin
      int         idx;
      logic [7:0] b;
      idx  = bit_cnt - 32;
      b    = mem[8'(cmd_last[7:0] + 8'(idx / 8))];
      miso = b[3'(7 - idx % 8)];
    end
  end

  // Scoreboard and timing monitor, sampled on the falling clock edge
  logic [7:0] exp_q[$];
  int cs_run = 0, sck_pos = 0, first_pos = 0, last_pos = 0, last_hi = 0;
  int last_cs_low = 0, last_sck_cnt = 0, last_first = 0, last_hi_run = 0;
  int rv_total = 0, done_total = 0;
  logic sck_d = 1'b0;

  always @(negedge sys_clk) begin
    if (!cs_n) begin
      cs_run++;
      if (sck && !sck_d) begin
        if (sck_pos > 0) chk("sck_period", 32'(cs_run - last_pos), 32'd4);
        else first_pos = cs_run;
        sck_pos++;
        last_pos = cs_run;
      end
      if (sck) last_hi = cs_run;
    end else if (cs_run != 0) begin
      last_cs_low  = cs_run;
      last_sck_cnt = sck_pos;
      last_first   = first_pos;
      last_hi_run  = last_hi;
      cs_run = 0;
      sck_pos = 0;
    end
    sck_d = sck;
    if (rd_valid) begin
      rv_total++;
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'd1, 32'd0);
      else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    if (done) done_total++;
  end

  int cs_run1 = 0, cs_low1 = 0, rv1 = 0;
  logic [7:0] last_rd1 = 8'd0;

  always @(negedge sys_clk) begin
    if (!cs_n1) cs_run1++;
    else if (cs_run1 != 0) begin
      cs_low1 = cs_run1;
      cs_run1 = 0;
    end
    if (rd_valid1) begin
      rv1++;
      last_rd1 = rd_data1;
    end
  end

  task automatic pulse_key();
    key = 1'b1;
    @(negedge sys_clk);
    key = 1'b0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < 100; i++) exp_q.push_back(mem[8'(8'h25 + i)]);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_txn(input string tag);
    chk({tag, "_cmd"},       cmd_last, 32'h03000425);
    chk({tag, "_cs_low"},    32'(last_cs_low), 32'd3392);
    chk({tag, "_sck_count"}, 32'(last_sck_cnt), 32'd832);
    chk({tag, "_sck_first"}, 32'(last_first), 32'd35);
    chk({tag, "_sck_last"},  32'(last_hi_run), 32'd3360);
    chk({tag, "_q_empty"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int rv0, dn0, n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i - 8'h25);

    repeat (3) @(negedge sys_clk);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Transaction 1: incrementing data, stray key at cycle 500
    rv0 = rv_total; dn0 = done_total;
    push_expected();
    pulse_key();
    chk("busy_start", 32'(busy), 32'd1);
    chk("cs_n_start", 32'(cs_n), 32'd0);
    repeat (499) @(negedge sys_clk);
    pulse_key();
    wait_done(4000);
    key = 1'b1;
    @(negedge sys_clk);
    key = 1'b0;
    chk("key_with_done_ignored", 32'(busy), 32'd0);
    chk("t1_rv_count", 32'(rv_total - rv0), 32'd100);
    chk("t1_done_count", 32'(done_total - dn0), 32'd1);
    check_txn("t1");

    // Transaction 2: 0xA5, 0x5A lead bytes, started 2 cycles after done
    mem[8'h25] = 8'hA5;
    mem[8'h26] = 8'h5A;
    rv0 = rv_total; dn0 = done_total;
    push_expected();
    pulse_key();
    chk("t2_busy", 32'(busy), 32'd1);
    wait_done(4000);
    repeat (2) @(negedge sys_clk);
    chk("t2_rv_count", 32'(rv_total - rv0), 32'd100);
    chk("t2_done_count", 32'(done_total - dn0), 32'd1);
    check_txn("t2");

    // Transaction 3: reset asserted during byte 40 of RECV
    rv0 = rv_total;
    push_expected();
    pulse_key();
    n = 0;
    while (rv_total - rv0 < 40 && n < 4000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t3_reached_byte40", 32'(rv_total - rv0), 32'd40);
    repeat (10) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    exp_q.delete();
    rv0 = rv_total; dn0 = done_total;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_no_valid", 32'(rv_total - rv0), 32'd0);
    chk("post_rst_no_done", 32'(done_total - dn0), 32'd0);

    // Transaction 4: full read after reset recovery
    mem[8'h25] = 8'h00;
    mem[8'h26] = 8'h01;
    rv0 = rv_total; dn0 = done_total;
    push_expected();
    pulse_key();
    wait_done(4000);
    repeat (2) @(negedge sys_clk);
    chk("t4_rv_count", 32'(rv_total - rv0), 32'd100);
    chk("t4_done_count", 32'(done_total - dn0), 32'd1);
    check_txn("t4");

    // NUM_DATA = 1 instance, miso held high
    key1 = 1'b1;
    @(negedge sys_clk);
    key1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    chk("n1_done_seen", 32'(done1), 32'd1);
    repeat (2) @(negedge sys_clk);
    chk("n1_rv_count", 32'(rv1), 32'd1);
    chk("n1_rd_data", 32'(last_rd1), 32'hFF);
    chk("n1_cs_low", 32'(cs_low1), 32'd224);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
